// File: rtl/rr_gather_arbiter_if.sv
// Requester-side and downstream-side handshake bundle for rr_gather_arbiter.
// The arbiter takes the slave view; the traffic source/sink takes the master view.
interface rr_gather_arbiter_if #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
);
    localparam int unsigned CHOSEN_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0]        io_in_valid;
    logic [NUM_IN-1:0]        io_in_ready;
    logic [NUM_IN*DATA_W-1:0] io_in_bits;
    logic [NUM_IN*TAG_W-1:0]  io_in_tag;
    logic [NUM_IN-1:0]        io_in_last;
    logic                     io_out_valid;
    logic                     io_out_ready;
    logic [DATA_W-1:0]        io_out_bits;
    logic [TAG_W-1:0]         io_out_tag;
    logic                     io_out_last;
    logic [CHOSEN_W-1:0]      io_chosen;
    logic                     io_locked;

    modport slave (
        input  io_in_valid, io_in_bits, io_in_tag, io_in_last, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_out_tag, io_out_last,
               io_chosen, io_locked
    );

    modport master (
        output io_in_valid, io_in_bits, io_in_tag, io_in_last, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_tag, io_out_last,
               io_chosen, io_locked
    );
endinterface

// File: rtl/rr_gather_arbiter.sv
// N-to-1 round-robin gather arbiter with optional burst lock and a one-entry
// registered output stage.
module rr_gather_arbiter #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned LOCK_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rr_gather_arbiter_if.slave    io
);
    localparam int unsigned CHOSEN_W = $clog2(NUM_IN);

    logic [CHOSEN_W-1:0] last_grant_q, last_grant_d;
    logic [CHOSEN_W-1:0] lock_idx_q,   lock_idx_d;
    logic                locked_q,     locked_d;
    logic                out_valid_q,  out_valid_d;
    logic [DATA_W-1:0]   out_bits_q,   out_bits_d;
    logic [TAG_W-1:0]    out_tag_q,    out_tag_d;
    logic                out_last_q,   out_last_d;
    logic [CHOSEN_W-1:0] chosen_q,     chosen_d;

    logic                can_accept;
    logic                grant_vld;
    logic [CHOSEN_W-1:0] grant_idx;
    logic [CHOSEN_W-1:0] scan_idx;
    logic                xfer;

    // Grant: lock owner only while locked, else first valid after last_grant.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (locked_q) begin
            grant_vld = 1'b1;
            grant_idx = lock_idx_q;
        end else begin
            for (int unsigned k = NUM_IN; k >= 1; k--) begin
                scan_idx = CHOSEN_W'((32'(last_grant_q) + k) % NUM_IN);
                if (io.io_in_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    assign can_accept     = !out_valid_q || io.io_out_ready;
    assign xfer           = grant_vld && can_accept && io.io_in_valid[grant_idx];
    assign io.io_in_ready = (grant_vld && can_accept) ? (NUM_IN'(1) << grant_idx) : '0;

    // Output stage, round-robin pointer and burst lock next state.
    always_comb begin
        last_grant_d = last_grant_q;
        lock_idx_d   = lock_idx_q;
        locked_d     = locked_q;
        out_valid_d  = out_valid_q;
        out_bits_d   = out_bits_q;
        out_tag_d    = out_tag_q;
        out_last_d   = out_last_q;
        chosen_d     = chosen_q;

        if (xfer) begin
            out_valid_d  = 1'b1;
            out_bits_d   = io.io_in_bits[32'(grant_idx)*DATA_W +: DATA_W];
            out_tag_d    = io.io_in_tag[32'(grant_idx)*TAG_W +: TAG_W];
            out_last_d   = io.io_in_last[grant_idx];
            chosen_d     = grant_idx;
            last_grant_d = grant_idx;
            if (LOCK_EN != 0) begin
                if (io.io_in_last[grant_idx]) begin
                    locked_d = 1'b0;
                end else if (!locked_q) begin
                    locked_d   = 1'b1;
                    lock_idx_d = grant_idx;
                end
            end
        end else if (io.io_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= CHOSEN_W'(NUM_IN - 1);
            lock_idx_q   <= '0;
            locked_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bits_q   <= '0;
            out_tag_q    <= '0;
            out_last_q   <= 1'b0;
            chosen_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_idx_q   <= lock_idx_d;
            locked_q     <= locked_d;
            out_valid_q  <= out_valid_d;
            out_bits_q   <= out_bits_d;
            out_tag_q    <= out_tag_d;
            out_last_q   <= out_last_d;
            chosen_q     <= chosen_d;
        end
    end

    assign io.io_out_valid = out_valid_q;
    assign io.io_out_bits  = out_bits_q;
    assign io.io_out_tag   = out_tag_q;
    assign io.io_out_last  = out_last_q;
    assign io.io_chosen    = chosen_q;
    assign io.io_locked    = locked_q;
endmodule

// File: tb/tb_rr_gather_arbiter.sv
// Bench for rr_gather_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level round-robin/lock model.
module tb_rr_gather_arbiter;
    localparam int unsigned NI = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 5;
    localparam int unsigned LE = 1;

    logic clk;
    logic reset_n;

    rr_gather_arbiter_if #(.NUM_IN(NI), .DATA_W(DW), .TAG_W(TW)) io ();

    rr_gather_arbiter #(.NUM_IN(NI), .DATA_W(DW), .TAG_W(TW), .LOCK_EN(LE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Reference model state
    int          m_last_grant;
    bit          m_locked;
    int          m_lock_idx;
    bit          m_out_valid;
    logic [DW-1:0] m_bits;
    logic [TW-1:0] m_tag;
    bit          m_last;
    int          m_chosen;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last_grant = NI - 1;
        m_locked     = 0;
        m_lock_idx   = 0;
        m_out_valid  = 0;
        m_bits       = '0;
        m_tag        = '0;
        m_last       = 0;
        m_chosen     = 0;
    endtask

    // Winner under the round-robin/lock rules, -1 when nobody is eligible.
    function automatic int model_grant(input logic [NI-1:0] v);
        if (m_locked) return m_lock_idx;
        for (int k = 1; k <= int'(NI); k++) begin
            int p;
            p = (m_last_grant + k) % int'(NI);
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(io.io_out_valid), 64'd0);
        check_eq("rst_locked",    64'(io.io_locked),    64'd0);
        check_eq("rst_chosen",    64'(io.io_chosen),    64'd0);
        check_eq("rst_bits",      64'(io.io_out_bits),  64'd0);
        model_reset();
        io.io_in_valid  = '0;
        io.io_in_last   = '0;
        io.io_in_bits   = '0;
        io.io_in_tag    = '0;
        io.io_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock: drive at negedge, check ready, advance model at posedge, check outputs.
    task automatic step(input logic [NI-1:0] v, input logic [NI-1:0] l, input logic ordy);
        logic [DW-1:0] b [NI];
        logic [TW-1:0] t [NI];
        logic [NI-1:0] exp_rdy;
        int  g;
        bit  can_acc;
        for (int i = 0; i < int'(NI); i++) begin
            b[i] = $urandom;
            t[i] = TW'($urandom);
            io.io_in_bits[i*DW +: DW] = b[i];
            io.io_in_tag[i*TW +: TW]  = t[i];
        end
        io.io_in_valid  = v;
        io.io_in_last   = l;
        io.io_out_ready = ordy;
        #1;
        can_acc = !m_out_valid || ordy;
        g = model_grant(v);
        exp_rdy = '0;
        if (g >= 0 && can_acc) exp_rdy[g] = 1'b1;
        check_eq("in_ready", 64'(io.io_in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (g >= 0 && can_acc && v[g]) begin
            m_out_valid  = 1;
            m_bits       = b[g];
            m_tag        = t[g];
            m_last       = l[g];
            m_chosen     = g;
            m_last_grant = g;
            if (LE != 0) begin
                if (l[g]) m_locked = 0;
                else if (!m_locked) begin
                    m_locked   = 1;
                    m_lock_idx = g;
                end
            end
        end else if (ordy) begin
            m_out_valid = 0;
        end
        #1;
        check_eq("out_valid", 64'(io.io_out_valid), 64'(m_out_valid));
        check_eq("locked",    64'(io.io_locked),    64'(m_locked));
        if (m_out_valid) begin
            check_eq("out_bits", 64'(io.io_out_bits), 64'(m_bits));
            check_eq("out_tag",  64'(io.io_out_tag),  64'(m_tag));
            check_eq("out_last", 64'(io.io_out_last), 64'(m_last));
            check_eq("chosen",   64'(io.io_chosen),   64'(m_chosen));
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        reset_n = 1'b1;
        io.io_in_valid  = '0;
        io.io_in_last   = '0;
        io.io_in_bits   = '0;
        io.io_in_tag    = '0;
        io.io_out_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // All ports valid, single-beat packets: 0,1,2,3,0 at one beat per cycle
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 4'b1111, 1'b1);
            check_eq("t1_chosen", 64'(io.io_chosen), 64'(c % 4));
            check_eq("t1_valid",  64'(io.io_out_valid), 64'd1);
        end

        // Lone requester on port 2 is served every cycle
        for (int c = 0; c < 4; c++) begin
            step(4'b0100, 4'($urandom), 1'b1);
            check_eq("t2_chosen", 64'(io.io_chosen), 64'd2);
        end
        step(4'b0100, 4'b0100, 1'b1);

        // Port 1 three-beat burst competing with ports 0 and 3
        do_reset();
        step(4'b0001, 4'b0001, 1'b1);
        begin
            logic [NI-1:0] lv [5];
            int exp_ch [5];
            lv = '{4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b1011};
            exp_ch = '{1, 1, 1, 3, 0};
            for (int c = 0; c < 5; c++) begin
                step(4'b1011, lv[c], 1'b1);
                check_eq("t3_chosen", 64'(io.io_chosen), 64'(exp_ch[c]));
            end
        end

        // Backpressure: full output held for 5 cycles, then drain plus reload
        step(4'b1111, 4'b1111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 4'b1111, 1'b0);
            check_eq("t4_rdy_zero", 64'(io.io_in_ready), 64'd0);
        end
        step(4'b1111, 4'b1111, 1'b1);

        // Locked burst on port 0 with a two-cycle valid gap; port 2 must wait
        do_reset();
        step(4'b0101, 4'b0000, 1'b1);
        check_eq("t5_lock", 64'(io.io_locked), 64'd1);
        for (int c = 0; c < 2; c++) begin
            io.io_in_valid = 4'b0100;
            #1;
            check_eq("t5_p2_stall", 64'(io.io_in_ready[2]), 64'd0);
            step(4'b0100, 4'b0000, 1'b1);
        end
        step(4'b0101, 4'b0000, 1'b1);
        check_eq("t5_mid", 64'(io.io_chosen), 64'd0);
        step(4'b0101, 4'b0001, 1'b1);
        check_eq("t5_last", 64'(io.io_chosen), 64'd0);
        step(4'b0100, 4'b0000, 1'b1);
        check_eq("t5_p2", 64'(io.io_chosen), 64'd2);
        step(4'b0100, 4'b0100, 1'b1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic [NI-1:0] v;
            logic [NI-1:0] l;
            for (int i = 0; i < int'(NI); i++) begin
                v[i] = ($urandom % 3) != 0;
                l[i] = ($urandom % 3) == 0;
            end
            step(v, l, ($urandom % 4) != 0);
        end

        // Reset while a locked beat sits in the output register
        do_reset();
        step(4'b0010, 4'b0000, 1'b0);
        check_eq("t6_pre_valid", 64'(io.io_out_valid), 64'd1);
        check_eq("t6_pre_lock",  64'(io.io_locked),    64'd1);
        do_reset();
        step(4'b1111, 4'b1111, 1'b1);
        check_eq("t6_first", 64'(io.io_chosen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
